// File: rtl/synth_pkg.sv
// Shared constants and helpers for the polyphonic voice allocator.
package synth_pkg;

    localparam int NVOICES = 4;
    localparam int NOTE_W  = 7;
    localparam int VEL_W   = 7;
    localparam int CHAN_W  = 4;
    localparam int RANK_W  = $clog2(NVOICES);
    localparam int VIDX_W  = $clog2(NVOICES);

    // Index of the lowest set bit of a voice mask; zero when the mask is empty.
    function automatic logic [VIDX_W-1:0] lowest_idx(input logic [NVOICES-1:0] mask);
        logic [VIDX_W-1:0] idx;
        idx = {VIDX_W{1'b0}};
        for (int i = NVOICES - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = VIDX_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Age ranking of voices: rank 0 is the most recently (re)triggered voice,
// rank NVOICES-1 is the oldest and is the one offered for stealing.
module voice_age_tracker #(
    parameter int NVOICES = synth_pkg::NVOICES
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      touch_i,
    input  logic [synth_pkg::VIDX_W-1:0]              touch_idx_i,
    output logic [NVOICES*synth_pkg::RANK_W-1:0]      rank_o,
    output logic [synth_pkg::VIDX_W-1:0]              oldest_o
);
    import synth_pkg::*;

    logic [RANK_W-1:0] rank_q [NVOICES];
    logic [RANK_W-1:0] rank_d [NVOICES];
    logic [RANK_W-1:0] age_s;

    // Move the touched voice to rank 0 and age every voice that was younger than it.
    always_comb begin
        age_s = rank_q[touch_idx_i];
        for (int i = 0; i < NVOICES; i++) begin
            rank_d[i] = rank_q[i];
        end
        if (touch_i) begin
            for (int i = 0; i < NVOICES; i++) begin
                if (VIDX_W'(i) == touch_idx_i) begin
                    rank_d[i] = {RANK_W{1'b0}};
                end else if (rank_q[i] < age_s) begin
                    rank_d[i] = rank_q[i] + RANK_W'(1);
                end else begin
                    rank_d[i] = rank_q[i];
                end
            end
        end else begin
            age_s = rank_q[touch_idx_i];
        end
    end

    // Rank registers; reset gives voice i rank i so the ranks start as a permutation.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NVOICES; i++) begin
                rank_q[i] <= RANK_W'(i);
            end
        end else begin
            for (int i = 0; i < NVOICES; i++) begin
                rank_q[i] <= rank_d[i];
            end
        end
    end

    // Locate the voice holding the oldest rank.
    always_comb begin
        oldest_o = {VIDX_W{1'b0}};
        for (int i = 0; i < NVOICES; i++) begin
            if (rank_q[i] == RANK_W'(NVOICES - 1)) begin
                oldest_o = VIDX_W'(i);
            end else begin
                oldest_o = oldest_o;
            end
        end
    end

    // Flatten ranks: voice i occupies bits [RANK_W*i +: RANK_W].
    always_comb begin
        rank_o = {(NVOICES*RANK_W){1'b0}};
        for (int i = 0; i < NVOICES; i++) begin
            rank_o[RANK_W*i +: RANK_W] = rank_q[i];
        end
    end

endmodule

// File: rtl/voice_alloc.sv
// Polyphonic voice allocator: maps MIDI note-on/off events onto a fixed pool
// of voices with retrigger, lowest-free allocation and oldest-voice stealing.
module voice_alloc #(
    parameter int NVOICES = synth_pkg::NVOICES
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  note_pressed,
    input  logic                                  note_released,
    input  logic [synth_pkg::NOTE_W-1:0]          note,
    input  logic [synth_pkg::VEL_W-1:0]           velocity,
    input  logic [synth_pkg::CHAN_W-1:0]          channel,
    input  logic                                  all_off,
    output logic [NVOICES-1:0]                    voice_active,
    output logic [synth_pkg::NOTE_W*NVOICES-1:0]  voice_note,
    output logic [synth_pkg::VEL_W*NVOICES-1:0]   voice_vel,
    output logic [NVOICES-1:0]                    voice_on_stb,
    output logic [NVOICES-1:0]                    voice_off_stb,
    output logic                                  drop_evt
);
    import synth_pkg::*;

    logic [NVOICES-1:0] active_q, active_d;
    logic [NOTE_W-1:0]  note_q [NVOICES];
    logic [NOTE_W-1:0]  note_d [NVOICES];
    logic [VEL_W-1:0]   vel_q  [NVOICES];
    logic [VEL_W-1:0]   vel_d  [NVOICES];
    logic [CHAN_W-1:0]  chan_q [NVOICES];
    logic [CHAN_W-1:0]  chan_d [NVOICES];
    logic [NVOICES-1:0] on_q, on_d;
    logic [NVOICES-1:0] off_q, off_d;
    logic               drop_q, drop_d;

    logic [NVOICES-1:0]        match_s;
    logic [NVOICES-1:0]        free_s;
    logic                      is_release_s;
    logic                      touch_s;
    logic [VIDX_W-1:0]         touch_idx_s;
    logic [VIDX_W-1:0]         tgt_s;
    logic [VIDX_W-1:0]         oldest_s;
    logic [NVOICES*RANK_W-1:0] rank_s;

    voice_age_tracker #(
        .NVOICES (NVOICES)
    ) u_age (
        .clk         (clk),
        .rst         (rst),
        .touch_i     (touch_s),
        .touch_idx_i (touch_idx_s),
        .rank_o      (rank_s),
        .oldest_o    (oldest_s)
    );

    // Voices currently sounding the requested note on the requested channel, and free voices.
    always_comb begin
        for (int i = 0; i < NVOICES; i++) begin
            match_s[i] = active_q[i] && (note_q[i] == note) && (chan_q[i] == channel);
        end
        free_s = ~active_q;
    end

    // Event decode: all_off beats note events, release beats press, velocity-0 press is a release.
    always_comb begin
        active_d     = active_q;
        for (int i = 0; i < NVOICES; i++) begin
            note_d[i] = note_q[i];
            vel_d[i]  = vel_q[i];
            chan_d[i] = chan_q[i];
        end
        on_d         = {NVOICES{1'b0}};
        off_d        = {NVOICES{1'b0}};
        drop_d       = 1'b0;
        touch_s      = 1'b0;
        touch_idx_s  = {VIDX_W{1'b0}};
        tgt_s        = {VIDX_W{1'b0}};
        is_release_s = note_released || (note_pressed && (velocity == {VEL_W{1'b0}}));

        if (all_off) begin
            active_d = {NVOICES{1'b0}};
            off_d    = active_q;
            drop_d   = note_pressed || note_released;
        end else if (is_release_s) begin
            // Note and velocity are held so a release tail can keep using them.
            active_d = active_q & ~match_s;
            off_d    = match_s;
            drop_d   = note_pressed && note_released;
        end else if (note_pressed) begin
            if (|match_s) begin
                tgt_s        = lowest_idx(match_s);
                vel_d[tgt_s] = velocity;
                on_d[tgt_s]  = 1'b1;
            end else if (|free_s) begin
                tgt_s           = lowest_idx(free_s);
                active_d[tgt_s] = 1'b1;
                note_d[tgt_s]   = note;
                vel_d[tgt_s]    = velocity;
                chan_d[tgt_s]   = channel;
                on_d[tgt_s]     = 1'b1;
            end else begin
                // Pool exhausted: steal the oldest voice, signalling both release and trigger.
                tgt_s          = oldest_s;
                note_d[tgt_s]  = note;
                vel_d[tgt_s]   = velocity;
                chan_d[tgt_s]  = channel;
                on_d[tgt_s]    = 1'b1;
                off_d[tgt_s]   = 1'b1;
            end
            touch_s     = 1'b1;
            touch_idx_s = tgt_s;
        end else begin
            drop_d = 1'b0;
        end
    end

    // Voice state and output strobe registers; reset discards any coincident event silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= {NVOICES{1'b0}};
            on_q     <= {NVOICES{1'b0}};
            off_q    <= {NVOICES{1'b0}};
            drop_q   <= 1'b0;
            for (int i = 0; i < NVOICES; i++) begin
                note_q[i] <= {NOTE_W{1'b0}};
                vel_q[i]  <= {VEL_W{1'b0}};
                chan_q[i] <= {CHAN_W{1'b0}};
            end
        end else begin
            active_q <= active_d;
            on_q     <= on_d;
            off_q    <= off_d;
            drop_q   <= drop_d;
            for (int i = 0; i < NVOICES; i++) begin
                note_q[i] <= note_d[i];
                vel_q[i]  <= vel_d[i];
                chan_q[i] <= chan_d[i];
            end
        end
    end

    // Pack per-voice note and velocity onto the flat output buses.
    always_comb begin
        voice_note = {(NOTE_W*NVOICES){1'b0}};
        voice_vel  = {(VEL_W*NVOICES){1'b0}};
        for (int i = 0; i < NVOICES; i++) begin
            voice_note[NOTE_W*i +: NOTE_W] = note_q[i];
            voice_vel[VEL_W*i +: VEL_W]    = vel_q[i];
        end
    end

    assign voice_active  = active_q;
    assign voice_on_stb  = on_q;
    assign voice_off_stb = off_q;
    assign drop_evt      = drop_q;

endmodule

// File: tb/tb_voice_alloc.sv
// Directed self-checking bench for voice_alloc.
module tb_voice_alloc;

    logic        clk = 1'b0;
    logic        rst;
    logic        note_pressed;
    logic        note_released;
    logic [6:0]  note;
    logic [6:0]  velocity;
    logic [3:0]  channel;
    logic        all_off;
    logic [3:0]  voice_active;
    logic [27:0] voice_note;
    logic [27:0] voice_vel;
    logic [3:0]  voice_on_stb;
    logic [3:0]  voice_off_stb;
    logic        drop_evt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    voice_alloc #(.NVOICES(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .note_pressed  (note_pressed),
        .note_released (note_released),
        .note          (note),
        .velocity      (velocity),
        .channel       (channel),
        .all_off       (all_off),
        .voice_active  (voice_active),
        .voice_note    (voice_note),
        .voice_vel     (voice_vel),
        .voice_on_stb  (voice_on_stb),
        .voice_off_stb (voice_off_stb),
        .drop_evt      (drop_evt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] vn(input int i);
        return voice_note[7*i +: 7];
    endfunction

    function automatic logic [6:0] vv(input int i);
        return voice_vel[7*i +: 7];
    endfunction

    // Apply the currently driven inputs for one clock, then idle the event lines.
    task automatic tick();
        @(posedge clk);
        #1;
        note_pressed  = 1'b0;
        note_released = 1'b0;
        all_off       = 1'b0;
        note          = 7'd0;
        velocity      = 7'd0;
        channel       = 4'd0;
    endtask

    task automatic press(input logic [6:0] n, input logic [6:0] v, input logic [3:0] c);
        note_pressed = 1'b1;
        note = n; velocity = v; channel = c;
        tick();
    endtask

    task automatic release_note(input logic [6:0] n, input logic [3:0] c);
        note_released = 1'b1;
        note = n; velocity = 7'd0; channel = c;
        tick();
    endtask

    task automatic strobes(input string tag, input logic [3:0] on, input logic [3:0] off,
                           input logic drop, input logic [3:0] act);
        chk({tag, "_on"},   32'(voice_on_stb),  32'(on));
        chk({tag, "_off"},  32'(voice_off_stb), 32'(off));
        chk({tag, "_drop"}, 32'(drop_evt),      32'(drop));
        chk({tag, "_act"},  32'(voice_active),  32'(act));
    endtask

    initial begin
        rst = 1'b1;
        note_pressed = 1'b0; note_released = 1'b0; all_off = 1'b0;
        note = 7'd0; velocity = 7'd0; channel = 4'd0;
        tick();
        tick();
        strobes("reset", 4'b0000, 4'b0000, 1'b0, 4'b0000);
        chk("reset_note", 32'(voice_note), 32'd0);
        chk("reset_vel",  32'(voice_vel),  32'd0);
        chk("reset_rank", 32'(dut.rank_s), 32'(8'b11_10_01_00));
        rst = 1'b0;
        tick();
        strobes("idle", 4'b0000, 4'b0000, 1'b0, 4'b0000);

        // First press lands on voice 0.
        press(7'd60, 7'd100, 4'd0);
        strobes("p60", 4'b0001, 4'b0000, 1'b0, 4'b0001);
        chk("p60_note", 32'(vn(0)), 32'd60);
        chk("p60_vel",  32'(vv(0)), 32'd100);
        press(7'd62, 7'd90, 4'd0);
        strobes("p62", 4'b0010, 4'b0000, 1'b0, 4'b0011);
        press(7'd64, 7'd80, 4'd0);
        strobes("p64", 4'b0100, 4'b0000, 1'b0, 4'b0111);
        press(7'd65, 7'd70, 4'd0);
        strobes("p65", 4'b1000, 4'b0000, 1'b0, 4'b1111);
        chk("p65_rank", 32'(dut.rank_s), 32'(8'b00_01_10_11));

        // Fifth press steals the oldest voice (voice 0).
        press(7'd67, 7'd60, 4'd0);
        strobes("steal", 4'b0001, 4'b0001, 1'b0, 4'b1111);
        chk("steal_note", 32'(vn(0)), 32'd67);
        chk("steal_vel",  32'(vv(0)), 32'd60);
        chk("steal_rank", 32'(dut.rank_s), 32'(8'b01_10_11_00));

        // Retrigger of 64 on voice 2: velocity updated, no off strobe.
        press(7'd64, 7'd20, 4'd0);
        strobes("retrig", 4'b0100, 4'b0000, 1'b0, 4'b1111);
        chk("retrig_vel",  32'(vv(2)), 32'd20);
        chk("retrig_note", 32'(vn(2)), 32'd64);
        chk("retrig_rank", 32'(dut.rank_s), 32'(8'b10_00_11_01));

        // Reset mid-sequence leaves no strobe behind.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        strobes("rst2", 4'b0000, 4'b0000, 1'b0, 4'b0000);

        // Velocity-0 press acts as release; note is held.
        press(7'd60, 7'd100, 4'd0);
        strobes("v0a", 4'b0001, 4'b0000, 1'b0, 4'b0001);
        press(7'd60, 7'd0, 4'd0);
        strobes("vel0", 4'b0000, 4'b0001, 1'b0, 4'b0000);
        chk("vel0_note", 32'(vn(0)), 32'd60);
        chk("vel0_vel",  32'(vv(0)), 32'd100);

        // Lowest free voice is reused after a release.
        press(7'd60, 7'd100, 4'd0);
        strobes("lf60", 4'b0001, 4'b0000, 1'b0, 4'b0001);
        press(7'd62, 7'd100, 4'd0);
        strobes("lf62", 4'b0010, 4'b0000, 1'b0, 4'b0011);
        release_note(7'd60, 4'd0);
        strobes("rel60", 4'b0000, 4'b0001, 1'b0, 4'b0010);
        press(7'd64, 7'd50, 4'd0);
        strobes("lf64", 4'b0001, 4'b0000, 1'b0, 4'b0011);
        chk("lf64_note", 32'(vn(0)), 32'd64);

        // Release matching nothing is silent.
        release_note(7'd99, 4'd0);
        strobes("relnone", 4'b0000, 4'b0000, 1'b0, 4'b0011);

        // Simultaneous press and release: release wins, press dropped.
        note_pressed = 1'b1; note_released = 1'b1;
        note = 7'd64; velocity = 7'd70; channel = 4'd0;
        tick();
        strobes("both", 4'b0000, 4'b0001, 1'b1, 4'b0010);

        // all_off with three voices active and a coincident press.
        press(7'd60, 7'd40, 4'd0);
        strobes("ao60", 4'b0001, 4'b0000, 1'b0, 4'b0011);
        press(7'd67, 7'd40, 4'd0);
        strobes("ao67", 4'b0100, 4'b0000, 1'b0, 4'b0111);
        all_off = 1'b1; note_pressed = 1'b1;
        note = 7'd72; velocity = 7'd40; channel = 4'd0;
        tick();
        strobes("alloff", 4'b0000, 4'b0111, 1'b0 | 1'b1, 4'b0000);

        // Reset overrides a coincident event with no drop.
        rst = 1'b1; note_pressed = 1'b1;
        note = 7'd50; velocity = 7'd30; channel = 4'd3;
        tick();
        rst = 1'b0;
        strobes("rstev", 4'b0000, 4'b0000, 1'b0, 4'b0000);
        chk("rstev_note", 32'(vn(0)), 32'd0);

        // Channel participates in matching.
        press(7'd50, 7'd30, 4'd3);
        strobes("ch3", 4'b0001, 4'b0000, 1'b0, 4'b0001);
        press(7'd50, 7'd31, 4'd5);
        strobes("ch5", 4'b0010, 4'b0000, 1'b0, 4'b0011);
        release_note(7'd50, 4'd5);
        strobes("relch5", 4'b0000, 4'b0010, 1'b0, 4'b0001);
        tick();
        strobes("quiet", 4'b0000, 4'b0000, 1'b0, 4'b0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter NVOICES, default 4, number of polyphonic voices; only value 4 is supported in this revision.
REQ-002 clk  input  1  system clock (32 MHz synth domain).
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 note_pressed  input  1  single-cycle note-on event pulse from the MIDI controller.
REQ-005 note_released  input  1  single-cycle note-off event pulse.
REQ-006 note  input  7  MIDI note number, valid while an event pulse is high.
REQ-007 velocity  input  7  MIDI velocity, valid while an event pulse is high.
REQ-008 channel  input  4  MIDI channel, valid while an event pulse is high.
REQ-009 all_off  input  1  single-cycle all-notes-off command.
REQ-010 voice_active  output  NVOICES  per-voice gate level.
REQ-011 voice_note  output  7*NVOICES  per-voice note; voice i occupies bits [7i+6:7i].
REQ-012 voice_vel  output  7*NVOICES  per-voice velocity, same packing.
REQ-013 voice_on_stb  output  NVOICES  one-cycle pulse: voice (re)triggered.
REQ-014 voice_off_stb  output  NVOICES  one-cycle pulse: voice released or stolen.
REQ-015 drop_evt  output  1  one-cycle pulse: event discarded.

Function
REQ-016 All outputs SHALL be registered; response appears exactly 1 cycle after the input event cycle.
REQ-017 The block SHALL keep per voice: active bit, note, velocity, channel, age rank 0..NVOICES-1 (0 = most recent); the ranks SHALL always form a permutation.
REQ-018 note_pressed with velocity 0 SHALL be handled exactly as note_released.
REQ-019 On a press: if an active voice holds the same note and channel, that voice SHALL be retriggered (velocity updated, on_stb pulsed, no off_stb).
REQ-020 Otherwise the lowest-index inactive voice SHALL be allocated: active=1, note/vel/channel loaded, on_stb pulsed.
REQ-021 If all voices are active, the voice with rank NVOICES-1 SHALL be stolen: off_stb and on_stb both pulse for it in the same cycle, new note/vel loaded, active stays 1.
REQ-022 On any allocation/retrigger of voice v with rank a: voices with rank < a increment by 1, v becomes 0, others are unchanged.
REQ-023 On a release: every active voice matching note and channel SHALL clear active and pulse off_stb; note/vel are held; ranks are unchanged.
REQ-024 A release that matches no active voice SHALL produce no voice strobe and no drop_evt.
REQ-025 note_pressed and note_released asserted in the same cycle: the release SHALL be processed, the press discarded, drop_evt pulsed.
REQ-026 all_off SHALL clear every active bit and pulse off_stb for each previously active voice; it has priority over simultaneous note events, which SHALL be discarded with drop_evt.
REQ-027 Inputs are sampled only on event cycles; note, velocity, channel are don't-care otherwise.
REQ-028 Back-to-back events on consecutive cycles SHALL each be processed with no loss.

Reset
REQ-029 While rst is high: voice_active=0, voice_note=0, voice_vel=0, all strobes and drop_evt=0, stored channels=0, rank of voice i = i.
REQ-030 rst SHALL override any event in the same cycle; the event is lost with no drop_evt.
REQ-031 Deasserting rst mid-sequence SHALL leave no pending strobe; the first event after reset behaves as from a cold start.

Structure
REQ-032 A shared package synth_pkg SHALL hold NVOICES, NOTE_W=7, VEL_W=7, CHAN_W=4 and the rank width.
REQ-033 Rank bookkeeping (update on allocation, oldest-voice select) SHALL be a sub-module voice_age_tracker; match/free search and state registers stay in voice_alloc.

Verification
REQ-034 After reset, press note 60 vel 100 ch 0 -> next cycle voice_on_stb=0001, voice_active=0001, voice 0 note=60 vel=100.
REQ-035 Press 60,62,64,65 then 67 -> the fifth press steals voice 0: on_stb=off_stb=0001, voice 0 note=67; ranks become v0=0,v1=3,v2=2,v3=1.
REQ-036 Press 60 vel 100, then press 60 vel 0 -> off_stb=0001, active=0000, note stays 60.
REQ-037 Press 60 (v0) and 62 (v1), release 60, press 64 -> 64 goes to voice 0 (lowest free), active=0011.
REQ-038 Same cycle note_pressed(70) and note_released(60) with 60 active on v0 -> off_stb=0001, drop_evt=1, 70 not allocated.
REQ-039 Three voices active, all_off with simultaneous press -> off_stb equals prior active mask, active=0000, drop_evt=1.
